// File: rtl/present_key_sched_if.sv
// Handshake bundle between the PRESENT-80 key schedule and the round stage that consumes its keys.
// The schedule itself connects through the slave modport; the consumer/driver side uses master.
interface present_key_sched_if;
    logic        start;
    logic [79:0] key;
    logic        rk_ready;
    logic        rk_valid;
    logic [63:0] round_key;
    logic [5:0]  round_idx;
    logic        last;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output key,
        output rk_ready,
        input  rk_valid,
        input  round_key,
        input  round_idx,
        input  last,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  key,
        input  rk_ready,
        output rk_valid,
        output round_key,
        output round_idx,
        output last,
        output busy,
        output done
    );
endinterface

// File: rtl/present_key_sched.sv
// Iterative PRESENT-80 key schedule: loads an 80-bit key and hands out round keys K1..K32,
// one per accepted valid/ready transfer; the key register only advances on a transfer.
module present_key_sched (
    input  logic               clk,
    input  logic               rst_n,
    present_key_sched_if.slave kif
);
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    localparam logic [5:0] LAST_IDX  = 6'd32;
    localparam logic [5:0] FIRST_IDX = 6'd1;

    state_t      state_q, state_d;
    logic [79:0] key_q,   key_d;
    logic [5:0]  idx_q,   idx_d;
    logic        done_q,  done_d;
    logic        emit;
    logic        xfer;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    // One full schedule step from the pre-update register: rotate, S-box the top nibble,
    // then fold the 5-bit round counter into bits 19:15.
    function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sbox(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

    assign emit = (state_q == ST_EMIT);
    assign xfer = emit && kif.rk_ready;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A start coinciding with the done pulse is dropped; next cycle is the earliest restart.
                if (kif.start && !done_q) begin
                    key_d   = kif.key;
                    idx_d   = FIRST_IDX;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d = key_update(key_q, idx_q[4:0]);
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Every output is a register or a decode of registers; rk_ready never reaches an output.
    assign kif.rk_valid  = emit;
    assign kif.busy      = emit;
    assign kif.done      = done_q;
    assign kif.round_idx = idx_q;
    assign kif.round_key = key_q[79:16];
    assign kif.last      = emit && (idx_q == LAST_IDX);
endmodule

// File: tb/tb_present_key_sched.sv
// Directed bench for present_key_sched: zero/all-ones keys, backpressure, start while busy,
// restart right after done, and reset during a stalled schedule.
module tb_present_key_sched;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    present_key_sched_if kif ();

    present_key_sched dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    int total = 0;
    int bad   = 0;

    logic [63:0] ref_keys  [1:32];
    logic [63:0] zero_keys [1:32];
    logic [63:0] got_keys  [1:32];
    logic [5:0]  got_idx   [1:32];
    logic        got_last  [1:32];
    int          nxfer, ncyc, valid_cycles, last_xfer_cyc, done_cyc, first_valid_cyc, stall_viol;
    logic        done_busy;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference key schedule written independently of the RTL: shift-based rotate, packed S-box table.
    task automatic build_ref(input logic [79:0] k0);
        logic [79:0] k;
        logic [63:0] sb;
        logic [3:0]  nib;
        sb = 64'h21748FE3DA09B65C;
        k  = k0;
        for (int r = 1; r <= 32; r++) begin
            ref_keys[r] = k[79:16];
            if (r < 32) begin
                k        = (k << 61) | (k >> 19);
                nib      = k[79:76];
                k[79:76] = sb[nib*4 +: 4];
                k[19:15] = k[19:15] ^ r[4:0];
            end
        end
    endtask

    // Drives one schedule and records every transfer; returns at the done cycle or on timeout.
    task automatic run_sched(input logic [79:0] k, input bit do_start, input int pct,
                             input int inject_idx, input int max_cyc);
        logic [63:0] prev_key;
        logic [5:0]  prev_idx;
        bit          prev_stall;
        nxfer = 0; ncyc = 0; valid_cycles = 0; stall_viol = 0;
        last_xfer_cyc = -1; done_cyc = -1; first_valid_cyc = -1; done_busy = 1'b1;
        prev_stall = 1'b0; prev_key = '0; prev_idx = '0;
        for (int i = 1; i <= 32; i++) begin
            got_keys[i] = '0; got_idx[i] = '0; got_last[i] = 1'b0;
        end
        if (do_start) begin
            kif.key = k; kif.start = 1'b1; kif.rk_ready = 1'b0;
            tick();
            kif.start = 1'b0; kif.key = '0;
        end
        while (ncyc < max_cyc) begin
            if (kif.done === 1'b1) begin
                done_cyc  = ncyc;
                done_busy = kif.busy;
                break;
            end
            if (prev_stall && (kif.rk_valid !== 1'b1 || kif.round_key !== prev_key ||
                               kif.round_idx !== prev_idx))
                stall_viol++;
            if (kif.rk_valid === 1'b1) begin
                if (first_valid_cyc < 0) first_valid_cyc = ncyc;
                valid_cycles++;
            end
            kif.rk_ready = ($urandom_range(0, 99) < pct);
            if (inject_idx > 0 && kif.round_idx == inject_idx) begin
                kif.start = 1'b1; kif.key = ~k;
            end else begin
                kif.start = 1'b0;
            end
            prev_stall = (kif.rk_valid === 1'b1) && !kif.rk_ready;
            prev_key   = kif.round_key;
            prev_idx   = kif.round_idx;
            if (kif.rk_valid === 1'b1 && kif.rk_ready) begin
                nxfer++;
                if (nxfer <= 32) begin
                    got_keys[nxfer] = kif.round_key;
                    got_idx[nxfer]  = kif.round_idx;
                    got_last[nxfer] = kif.last;
                end
                last_xfer_cyc = ncyc;
            end
            tick();
            ncyc++;
        end
        kif.start = 1'b0; kif.rk_ready = 1'b0; kif.key = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; kif.start = 1'b1; kif.key = {80{1'b1}}; kif.rk_ready = 1'b1;
        repeat (3) tick();
        total++; if (kif.rk_valid !== 1'b0) begin bad++; $display("FAIL reset_rk_valid got=%b want=0", kif.rk_valid); end
        total++; if (kif.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", kif.busy); end
        total++; if (kif.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", kif.done); end
        total++; if (kif.last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", kif.last); end
        total++; if (kif.round_key !== 64'h0) begin bad++; $display("FAIL reset_round_key got=%h want=0", kif.round_key); end
        total++; if (kif.round_idx !== 6'd0) begin bad++; $display("FAIL reset_round_idx got=%0d want=0", kif.round_idx); end
        kif.start = 1'b0; kif.key = '0; kif.rk_ready = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();
        total++; if (kif.rk_valid !== 1'b0) begin bad++; $display("FAIL idle_after_reset got=%b want=0", kif.rk_valid); end
    endtask

    task automatic test_zero_key();
        int last_err, idx_err, key_err;
        build_ref(80'h0);
        for (int i = 1; i <= 32; i++) zero_keys[i] = ref_keys[i];
        run_sched(80'h0, 1'b1, 100, 0, 100);
        total++; if (first_valid_cyc !== 0) begin bad++; $display("FAIL zero_latency got=%0d want=0", first_valid_cyc); end
        total++; if (got_keys[1] !== 64'h0000000000000000) begin bad++; $display("FAIL zero_K1 got=%h want=0000000000000000", got_keys[1]); end
        total++; if (got_keys[2] !== 64'hC000000000000000) begin bad++; $display("FAIL zero_K2 got=%h want=c000000000000000", got_keys[2]); end
        total++; if (got_keys[3] !== 64'h5000180000000001) begin bad++; $display("FAIL zero_K3 got=%h want=5000180000000001", got_keys[3]); end
        last_err = 0; idx_err = 0; key_err = 0;
        for (int i = 1; i <= 32; i++) begin
            if (got_last[i] !== (i == 32)) last_err++;
            if (got_idx[i] !== 6'(i)) idx_err++;
            if (got_keys[i] !== zero_keys[i]) key_err++;
        end
        total++; if (last_err != 0) begin bad++; $display("FAIL zero_last_pattern got=%0d wrong want=0", last_err); end
        total++; if (idx_err != 0) begin bad++; $display("FAIL zero_idx_sequence got=%0d wrong want=0", idx_err); end
        total++; if (key_err != 0) begin bad++; $display("FAIL zero_key_sequence got=%0d wrong want=0", key_err); end
        total++; if (valid_cycles != 32) begin bad++; $display("FAIL zero_valid_cycles got=%0d want=32", valid_cycles); end
        total++; if (last_xfer_cyc != 31) begin bad++; $display("FAIL zero_last_xfer_cycle got=%0d want=31", last_xfer_cyc); end
        total++; if (done_cyc != 32) begin bad++; $display("FAIL zero_done_cycle got=%0d want=32", done_cyc); end
        total++; if (done_busy !== 1'b0) begin bad++; $display("FAIL zero_busy_at_done got=%b want=0", done_busy); end
        tick();
        total++; if (kif.done !== 1'b0) begin bad++; $display("FAIL zero_done_width got=%b want=0", kif.done); end
    endtask

    task automatic test_ones_key();
        int key_err;
        build_ref({80{1'b1}});
        run_sched({80{1'b1}}, 1'b1, 100, 0, 100);
        total++; if (got_keys[1] !== 64'hFFFFFFFFFFFFFFFF) begin bad++; $display("FAIL ones_K1 got=%h want=ffffffffffffffff", got_keys[1]); end
        total++; if (got_keys[2] !== 64'h2FFFFFFFFFFFFFFF) begin bad++; $display("FAIL ones_K2 got=%h want=2fffffffffffffff", got_keys[2]); end
        key_err = 0;
        for (int i = 1; i <= 32; i++) begin
            total++;
            if (got_keys[i] !== ref_keys[i]) begin
                bad++; key_err++;
                $display("FAIL ones_K%0d got=%h want=%h", i, got_keys[i], ref_keys[i]);
            end
        end
        total++; if (done_cyc != 32) begin bad++; $display("FAIL ones_done_cycle got=%0d want=32", done_cyc); end
        tick();
    endtask

    task automatic test_backpressure();
        int key_err;
        run_sched(80'h0, 1'b1, 40, 0, 600);
        key_err = 0;
        for (int i = 1; i <= 32; i++) if (got_keys[i] !== zero_keys[i]) key_err++;
        total++; if (key_err != 0) begin bad++; $display("FAIL bp_key_sequence got=%0d wrong want=0", key_err); end
        total++; if (stall_viol != 0) begin bad++; $display("FAIL bp_stall_hold got=%0d changes want=0", stall_viol); end
        total++; if (nxfer != 32) begin bad++; $display("FAIL bp_transfers got=%0d want=32", nxfer); end
        total++; if (done_cyc < 0 || done_cyc != last_xfer_cyc + 1) begin bad++; $display("FAIL bp_done_cycle got=%0d want=%0d", done_cyc, last_xfer_cyc + 1); end
        tick();
    endtask

    task automatic test_back_to_back_busy_start();
        int key_err;
        run_sched(80'h0, 1'b1, 100, 5, 100);
        key_err = 0;
        for (int i = 1; i <= 32; i++) if (got_keys[i] !== zero_keys[i]) key_err++;
        total++; if (key_err != 0) begin bad++; $display("FAIL busy_start_sequence got=%0d wrong want=0", key_err); end
        total++; if (nxfer != 32) begin bad++; $display("FAIL busy_start_transfers got=%0d want=32", nxfer); end
        total++; if (done_cyc != 32) begin bad++; $display("FAIL busy_start_done_cycle got=%0d want=32", done_cyc); end
        tick();
    endtask

    task automatic test_restart();
        int key_err;
        run_sched(80'h0, 1'b1, 100, 0, 100);
        total++; if (done_cyc != 32) begin bad++; $display("FAIL restart_first_done got=%0d want=32", done_cyc); end
        // Start raised during the done cycle must be dropped, then accepted one cycle later.
        kif.start = 1'b1; kif.key = {80{1'b1}};
        tick();
        total++; if (kif.rk_valid !== 1'b0) begin bad++; $display("FAIL restart_start_in_done got=%b want=0", kif.rk_valid); end
        tick();
        kif.start = 1'b0; kif.key = '0;
        total++; if (kif.rk_valid !== 1'b1) begin bad++; $display("FAIL restart_valid got=%b want=1", kif.rk_valid); end
        total++; if (kif.round_idx !== 6'd1) begin bad++; $display("FAIL restart_idx got=%0d want=1", kif.round_idx); end
        total++; if (kif.round_key !== 64'hFFFFFFFFFFFFFFFF) begin bad++; $display("FAIL restart_K1 got=%h want=ffffffffffffffff", kif.round_key); end
        build_ref({80{1'b1}});
        run_sched({80{1'b1}}, 1'b0, 100, 0, 100);
        key_err = 0;
        for (int i = 1; i <= 32; i++) if (got_keys[i] !== ref_keys[i]) key_err++;
        total++; if (key_err != 0) begin bad++; $display("FAIL restart_sequence got=%0d wrong want=0", key_err); end
        total++; if (done_cyc != 32) begin bad++; $display("FAIL restart_done_cycle got=%0d want=32", done_cyc); end
        tick();
    endtask

    task automatic test_reset_mid();
        int guard, done_pulses, key_err;
        kif.key = 80'h0; kif.start = 1'b1; kif.rk_ready = 1'b0;
        tick();
        kif.start = 1'b0; kif.rk_ready = 1'b1;
        guard = 0;
        while (kif.round_idx != 6'd10 && guard < 50) begin tick(); guard++; end
        kif.rk_ready = 1'b0;
        repeat (2) tick();
        total++; if (kif.round_idx !== 6'd10 || kif.round_key !== zero_keys[10]) begin bad++; $display("FAIL rstmid_stalled_at_K10 got=%0d/%h want=10/%h", kif.round_idx, kif.round_key, zero_keys[10]); end
        rst_n = 1'b0;
        tick();
        total++; if (kif.rk_valid !== 1'b0) begin bad++; $display("FAIL rstmid_rk_valid got=%b want=0", kif.rk_valid); end
        total++; if (kif.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", kif.busy); end
        total++; if (kif.last !== 1'b0 || kif.done !== 1'b0) begin bad++; $display("FAIL rstmid_last_done got=%b%b want=00", kif.last, kif.done); end
        total++; if (kif.round_key !== 64'h0) begin bad++; $display("FAIL rstmid_round_key got=%h want=0", kif.round_key); end
        total++; if (kif.round_idx !== 6'd0) begin bad++; $display("FAIL rstmid_round_idx got=%0d want=0", kif.round_idx); end
        rst_n = 1'b1;
        kif.rk_ready = 1'b1;
        done_pulses = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (kif.done === 1'b1) done_pulses++;
        end
        kif.rk_ready = 1'b0;
        total++; if (done_pulses != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", done_pulses); end
        run_sched(80'h0, 1'b1, 100, 0, 100);
        key_err = 0;
        for (int i = 1; i <= 32; i++) if (got_keys[i] !== zero_keys[i]) key_err++;
        total++; if (key_err != 0) begin bad++; $display("FAIL rstmid_clean_sequence got=%0d wrong want=0", key_err); end
        total++; if (nxfer != 32 || done_cyc != 32) begin bad++; $display("FAIL rstmid_clean_done got=%0d/%0d want=32/32", nxfer, done_cyc); end
        tick();
    endtask

    initial begin
        rst_n = 1'b0; kif.start = 1'b0; kif.key = '0; kif.rk_ready = 1'b0;
        test_reset();
        test_zero_key();
        test_ones_key();
        test_backpressure();
        test_back_to_back_busy_start();
        test_restart();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/present_key_sched.md
# present_key_sched

Iterative PRESENT-80 key schedule that sits directly upstream of the round stage `p`. It loads an 80-bit user key and emits the 32 round keys K1..K32 one at a time over a valid/ready handshake, so the round stage can consume one key per round. The 80-bit key register advances only when a key is accepted, so a stall in the round stage never loses or skips a key.

## Interface
- No parameters; PRESENT-80 only (80-bit key, 32 round keys).
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  request: load `key` and begin the schedule; honoured only when `busy`=0.
- key  in  80  user key, bit 79 = MSB; sampled on the accepted `start` cycle only.
- rk_ready  in  1  downstream round stage can take a round key this cycle.
- rk_valid  out  1  `round_key` and `round_idx` are valid.
- round_key  out  64  current round key = key register bits [79:16].
- round_idx  out  6  index of the presented key, 1..32.
- last  out  1  high together with `rk_valid` while K32 is presented.
- busy  out  1  a schedule is in progress, from start acceptance until K32 is accepted.
- done  out  1  one-cycle pulse after K32 is accepted.

## Operation
- State machine:
  - IDLE: `busy`=0, `rk_valid`=0.
  - On `start`=1 in IDLE: key_reg<=key, idx<=1, go to EMIT.
  - EMIT: `busy`=1, `rk_valid`=1.
  - Transfer = `rk_valid` & `rk_ready`.
  - Transfer with idx<32: apply the update step, idx<=idx+1, stay in EMIT.
  - Transfer with idx=32: go to IDLE, `done`<=1 for one cycle; key_reg holds its value.
- Update step, using the current idx i (1..31), applied in this order:
  - rotate left by 61: k <= {k[18:0], k[79:19]}.
  - k[79:76] <= S(k[79:76]), PRESENT S-box C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 for inputs 0..F.
  - k[19:15] <= k[19:15] ^ i[4:0].
  - The whole step is one combinational function of the pre-update register, committed in one edge.
- `round_key` = key_reg[79:16] at all times. Its value outside EMIT carries no meaning.
- `last` = EMIT & (idx==32).
- `start` while `busy`=1 is ignored; `key` is not resampled.
- `start` in the same cycle that `done` pulses is not accepted. IDLE is entered on that edge, so the earliest new start is the following cycle.
- When `rk_ready` is low, outputs hold exactly, with no change to key, idx or valid.
- `rk_ready` has no effect in IDLE.

## Timing
- Reset values (rst_n low at an edge), all zero:
  - state=IDLE, key_reg=0, idx=0.
  - rk_valid=0, last=0, busy=0, done=0.
  - round_key=0, round_idx=0.
- Reset mid-schedule aborts at the next edge; no `done` pulse is produced.
- Latency: `start` accepted at edge N gives `rk_valid`=1 with K1 during cycle N+1. K1 equals the loaded key[79:16].
- Throughput: with `rk_ready` held high, one key per cycle. K1..K32 occupy cycles N+1..N+32, then `done`=1 in cycle N+33 with `busy`=0.
- `rk_valid` must never drop once raised until K32 transfers.
- Registered outputs: rk_valid, busy, done, idx, key_reg.
- Combinational outputs: round_key and last, decoded from registers only. There is no combinational path from `rk_ready` to any output.

## Test plan
- Zero key, `rk_ready`=1:
  - K1=0000000000000000, K2=C000000000000000, K3=5000180000000001.
  - `last` on idx 32 only.
  - `done` one cycle after K32; total 32 valid cycles.
- All-ones key (80'hFFFF_FFFF_FFFF_FFFF_FFFF):
  - K1=FFFFFFFFFFFFFFFF, K2=2FFFFFFFFFFFFFFF.
  - Compare all 32 keys against a reference model.
- Backpressure: random `rk_ready` (~40% high), zero key.
  - Keys must hold stable while stalled.
  - The sequence is identical to the unstalled run; exactly 32 transfers, then `done`.
- Start while busy: assert `start` with a different key at K5.
  - Ignored; the sequence continues from the original key.
- Restart: new `start` in the cycle after `done`.
  - Accepted; K1 of the new key appears in the next cycle.
- Reset at K10 while stalled:
  - All outputs 0 at the next edge, no `done`.
  - A subsequent `start` produces a clean K1..K32.
